rom_rd_arb: RTL and testbench
=============================

ROM_RD_ARB -- requirements
Module: rom_rd_arb

Interface
REQ-001 SHALL have parameter ROM_LAT, default 1, cycles from rom_rd_en high to rom_data valid (legal 1..4).
REQ-002 SHALL have parameter ADDR_W, default 8, ROM address width.
REQ-003 SHALL have parameter DATA_W, default 8, ROM data width.
REQ-004 sys_clk  in  1  single clock; all logic rising-edge.
REQ-005 sys_rst_n  in  1  asynchronous, active-low reset.
REQ-006 arb_en  in  1  high = grants allowed; low = no new grants, in-flight reads complete.
REQ-007 req_i  in  2  per-requester read request; held with addr until accepted.
REQ-008 addr0_i / addr1_i  in  ADDR_W each  requester read addresses.
REQ-009 gnt_o  out  2  combinational grant; one-hot or zero.
REQ-010 rom_rd_en  out  1  registered ROM read strobe.
REQ-011 rom_addr  out  ADDR_W  registered ROM address.
REQ-012 rom_data  in  DATA_W  ROM read data, valid ROM_LAT cycles after rom_rd_en.
REQ-013 rd_valid_o  out  2  one-cycle pulse per completed read, one-hot.
REQ-014 rd_data_o  out  DATA_W  registered read data, shared by both requesters.

Function
REQ-015 Acceptance: request k accepted in cycle C iff req_i[k] & gnt_o[k] high at the rising edge ending C.
REQ-016 gnt_o SHALL be zero when arb_en low or req_i zero.
REQ-017 Single requester active with arb_en high: gnt_o to that requester every cycle (throughput 1 read/cycle).
REQ-018 Both requesting: grant to requester not accepted most recently (round-robin); after reset requester 0 wins first tie.
REQ-019 Round-robin pointer SHALL update only on acceptance, never on unaccepted grant.
REQ-020 Accepted in cycle C: rom_rd_en=1, rom_addr=accepted addr in cycle C+1; rom_rd_en=0 in cycles with no prior acceptance; rom_addr holds last value.
REQ-021 rd_valid_o[k]=1, rd_data_o=ROM word in cycle C+2+ROM_LAT (C+3 at default); exactly one pulse per acceptance, in acceptance order.
REQ-022 Owner tag SHALL be carried in a shift pipeline of depth ROM_LAT+1 alongside the strobe; back-to-back reads from alternating requesters SHALL return to correct owners.
REQ-023 rd_data_o SHALL hold last value when rd_valid_o is zero.
REQ-024 arb_en falling mid-stream: reads already accepted SHALL complete with normal latency; no new acceptance until arb_en high.
REQ-025 req_i deasserted before acceptance: no read issued, pointer unchanged.
REQ-026 No address range check; all 2^ADDR_W addresses legal, 0 and max pass unmodified.

Reset
REQ-027 On sys_rst_n low: rom_rd_en=0, rom_addr=0, rd_valid_o=0, rd_data_o=0, tag pipeline cleared, pointer = requester 0 priority.
REQ-028 Reset mid-operation SHALL discard all in-flight reads; no rd_valid_o pulse for reads accepted before reset.
REQ-029 gnt_o SHALL be zero while sys_rst_n low regardless of req_i.

Structure
REQ-030 Shared package rom_arb_pkg SHALL hold ADDR_W, DATA_W defaults, NUM_REQ=2, ROM_LAT default and the owner-tag type.
REQ-031 Owner-tag/valid delay line SHALL be sub-module rom_arb_tag_pipe (parameterised depth); picker logic stays in top.
REQ-032 Implementation SHALL be 120-400 lines of RTL, no memories inside block.

Verification
REQ-033 Reset, then req_i=01, addr0=8'h10 one cycle -> gnt_o=01 same cycle, rom_rd_en/rom_addr=8'h10 next cycle, rd_valid_o=01 with ROM[16] three cycles after acceptance.
REQ-034 req_i=11 held 6 cycles, addr0=8'h00, addr1=8'hFF -> grants alternate 01,10,01,10,01,10; six rd_valid pulses alternating owner with ROM[0]/ROM[255].
REQ-035 req_i=10 held 4 cycles, addr1 incrementing 8'h63..8'h66 -> 4 back-to-back rom_rd_en, rd_valid_o=10 four consecutive cycles with ROM[99..102].
REQ-036 Two reads accepted, arb_en dropped next cycle with req_i=11 -> gnt_o=00, both pending rd_valid pulses still delivered, no further reads.
REQ-037 Read accepted, sys_rst_n pulsed low one cycle later -> no rd_valid_o pulse, all outputs zero, next tie grants requester 0.
REQ-038 ROM_LAT=3 build, alternating reads -> rd_valid_o at acceptance+5 with correct owner each.

Source files
------------

// File: rtl/rom_arb_pkg.sv
// Shared definitions for the two-requester ROM read arbiter.
// Latency: n/a (types, defaults and helpers only).
// Backpressure: n/a.
package rom_arb_pkg;

    localparam int ADDR_W_DEF  = 8;
    localparam int DATA_W_DEF  = 8;
    localparam int NUM_REQ     = 2;
    localparam int ROM_LAT_DEF = 1;

    // Index of the requester that owns a read in flight.
    typedef logic owner_t;

    function automatic logic [NUM_REQ-1:0] owner_onehot(input owner_t owner);
        return owner ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/rom_arb_tag_pipe.sv
// Valid/owner-tag delay line that tracks each ROM read until its data is due.
// Latency: DEPTH cycles from i_vld to o_vld.
// Backpressure: none; one entry may enter every cycle.
//
// Ports: i_clk, i_rst_n (async, active-low), i_vld/i_tag (accepted read),
//        o_vld/o_tag (read whose ROM data is on the bus this cycle).
module rom_arb_tag_pipe
    import rom_arb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic   i_clk,
    input  logic   i_rst_n,
    input  logic   i_vld,
    input  owner_t i_tag,
    output logic   o_vld,
    output owner_t o_tag
);

    logic [DEPTH-1:0] r_vld;
    owner_t           r_tag [DEPTH];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_vld <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_tag[i] <= 1'b0;
            end
        end else begin
            r_vld[0] <= i_vld;
            r_tag[0] <= i_tag;
            for (int i = 1; i < DEPTH; i++) begin
                r_vld[i] <= r_vld[i-1];
                r_tag[i] <= r_tag[i-1];
            end
        end
    end

    assign o_vld = r_vld[DEPTH-1];
    assign o_tag = r_tag[DEPTH-1];

endmodule

// File: rtl/rom_rd_arb.sv
// Round-robin arbiter sharing one fixed-latency ROM read port between two requesters.
// Latency: grant same cycle; rom_rd_en next cycle; rd_valid_o ROM_LAT+2 cycles after acceptance.
// Backpressure: a requester holds req_i/addr until granted; arb_en low blocks new grants only.
//
// Ports: sys_clk, sys_rst_n (async, active-low), arb_en, req_i[1:0],
//        addr0_i/addr1_i, gnt_o[1:0] (combinational), rom_rd_en/rom_addr (registered),
//        rom_data (ROM_LAT cycles after strobe), rd_valid_o[1:0]/rd_data_o (registered).
module rom_rd_arb
    import rom_arb_pkg::*;
#(
    parameter int ROM_LAT = ROM_LAT_DEF,   // legal 1..4
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              arb_en,
    input  logic [1:0]        req_i,
    input  logic [ADDR_W-1:0] addr0_i,
    input  logic [ADDR_W-1:0] addr1_i,
    output logic [1:0]        gnt_o,
    output logic              rom_rd_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic [1:0]        rd_valid_o,
    output logic [DATA_W-1:0] rd_data_o
);

    // Tie-break owner: 0 = requester 0 wins a tie, 1 = requester 1 wins.
    logic r_prio;

    logic [1:0]        w_gnt;
    logic              w_acc;
    owner_t            w_acc_tag;
    logic [ADDR_W-1:0] w_acc_addr;
    logic              w_pipe_vld;
    owner_t            w_pipe_tag;

    // Reset is folded into the grant so nothing is granted while held in reset.
    always_comb begin
        w_gnt = 2'b00;
        if (sys_rst_n && arb_en) begin
            case (req_i)
                2'b01:   w_gnt = 2'b01;
                2'b10:   w_gnt = 2'b10;
                2'b11:   w_gnt = r_prio ? 2'b10 : 2'b01;
                default: w_gnt = 2'b00;
            endcase
        end
    end

    assign gnt_o      = w_gnt;
    assign w_acc      = |(req_i & w_gnt);
    assign w_acc_tag  = w_gnt[1];
    assign w_acc_addr = w_gnt[1] ? addr1_i : addr0_i;

    // Pointer moves only on a real acceptance; the winner drops to lower priority.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_prio    <= 1'b0;
            rom_rd_en <= 1'b0;
            rom_addr  <= '0;
        end else begin
            rom_rd_en <= w_acc;
            if (w_acc) begin
                rom_addr <= w_acc_addr;
                r_prio   <= ~w_acc_tag;
            end
        end
    end

    // Stage 0 lines up with rom_rd_en; the last stage lines up with rom_data.
    rom_arb_tag_pipe #(
        .DEPTH (ROM_LAT + 1)
    ) u_tag_pipe (
        .i_clk   (sys_clk),
        .i_rst_n (sys_rst_n),
        .i_vld   (w_acc),
        .i_tag   (w_acc_tag),
        .o_vld   (w_pipe_vld),
        .o_tag   (w_pipe_tag)
    );

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rd_valid_o <= 2'b00;
            rd_data_o  <= '0;
        end else begin
            rd_valid_o <= w_pipe_vld ? owner_onehot(w_pipe_tag) : 2'b00;
            if (w_pipe_vld) begin
                rd_data_o <= rom_data;
            end
        end
    end

endmodule

// File: tb/tb_rom_rd_arb.sv
module tb_rom_rd_arb;
    import rom_arb_pkg::*;

    logic       sys_clk   = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic       arb_en    = 1'b0;
    logic [1:0] req_i     = 2'b00;
    logic [7:0] addr0_i   = 8'h00;
    logic [7:0] addr1_i   = 8'h00;

    // Default-latency instance
    logic [1:0] gnt_o, rd_valid_o;
    logic       rom_rd_en;
    logic [7:0] rom_addr, rom_data, rd_data_o;
    // ROM_LAT=3 instance, same stimulus
    logic [1:0] gnt3, rd_valid3;
    logic       rom_rd_en3;
    logic [7:0] rom_addr3, rom_data3, rd_data3;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 sys_clk = ~sys_clk;

    rom_rd_arb #(.ROM_LAT(1), .ADDR_W(8), .DATA_W(8)) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .arb_en(arb_en), .req_i(req_i),
        .addr0_i(addr0_i), .addr1_i(addr1_i), .gnt_o(gnt_o), .rom_rd_en(rom_rd_en),
        .rom_addr(rom_addr), .rom_data(rom_data), .rd_valid_o(rd_valid_o), .rd_data_o(rd_data_o)
    );

    rom_rd_arb #(.ROM_LAT(3), .ADDR_W(8), .DATA_W(8)) dut3 (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .arb_en(arb_en), .req_i(req_i),
        .addr0_i(addr0_i), .addr1_i(addr1_i), .gnt_o(gnt3), .rom_rd_en(rom_rd_en3),
        .rom_addr(rom_addr3), .rom_data(rom_data3), .rd_valid_o(rd_valid3), .rd_data_o(rd_data3)
    );

    // ROM content: word = address ^ 8'h5A
    function automatic logic [7:0] rom_f(input logic [7:0] a);
        return a ^ 8'h5A;
    endfunction

    // ROM models: data appears ROM_LAT cycles after the strobe cycle.
    logic [7:0] rp1;
    logic [7:0] rp3 [3];
    always @(posedge sys_clk) begin
        rp1    <= rom_addr;
        rp3[0] <= rom_addr3;
        rp3[1] <= rp3[0];
        rp3[2] <= rp3[1];
    end
    assign rom_data  = rom_f(rp1);
    assign rom_data3 = rom_f(rp3[2]);

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    // n cycles of requests with pattern pat; addresses base + inc*t.
    // Checks grants, strobes, and both instances' return pulses.
    task automatic burst(input int n, input logic [1:0] pat, input logic [7:0] a0,
                         input logic [7:0] a1, input logic [7:0] inc, input logic first);
        logic       own [16];
        logic [7:0] adr [16];
        logic       o;
        logic [7:0] a0_t, a1_t;
        o = first;
        for (int t = 0; t < n; t++) begin
            own[t] = (pat == 2'b11) ? o : pat[1];
            o      = ~own[t];
            a0_t   = a0 + inc * t[7:0];
            a1_t   = a1 + inc * t[7:0];
            adr[t] = own[t] ? a1_t : a0_t;
        end
        for (int t = 0; t < n + 5; t++) begin
            if (t < n) begin
                req_i   = pat;
                addr0_i = a0 + inc * t[7:0];
                addr1_i = a1 + inc * t[7:0];
            end else begin
                req_i = 2'b00;
            end
            #1;
            check_val("burst_gnt",  gnt_o, (t < n) ? owner_onehot(own[t]) : 2'b00);
            check_val("burst_gnt3", gnt3,  (t < n) ? owner_onehot(own[t]) : 2'b00);
            tick();
            check_val("burst_rd_en", rom_rd_en, (t < n));
            if (t < n) check_val("burst_rom_addr", rom_addr, adr[t]);
            if (t >= 2 && t - 2 < n) begin
                check_val("burst_valid", rd_valid_o, owner_onehot(own[t-2]));
                check_val("burst_data",  rd_data_o,  rom_f(adr[t-2]));
            end else begin
                check_val("burst_valid_idle", rd_valid_o, 2'b00);
            end
            if (t >= 4 && t - 4 < n) begin
                check_val("lat3_valid", rd_valid3, owner_onehot(own[t-4]));
                check_val("lat3_data",  rd_data3,  rom_f(adr[t-4]));
            end else begin
                check_val("lat3_valid_idle", rd_valid3, 2'b00);
            end
        end
    endtask

    initial begin
        // ---------------- reset state ----------------
        arb_en = 1'b1;
        req_i  = 2'b11;
        #2;
        check_val("rst_gnt",      gnt_o,      2'b00);
        check_val("rst_rd_en",    rom_rd_en,  1'b0);
        check_val("rst_rom_addr", rom_addr,   8'h00);
        check_val("rst_valid",    rd_valid_o, 2'b00);
        check_val("rst_data",     rd_data_o,  8'h00);
        tick();
        tick();
        sys_rst_n = 1'b1;
        req_i     = 2'b00;
        tick();

        // ---------------- single read, requester 0 ----------------
        req_i   = 2'b01;
        addr0_i = 8'h10;
        #1;
        check_val("t1_gnt", gnt_o, 2'b01);
        tick();                                     // C+1
        req_i = 2'b00;
        #1;
        check_val("t1_gnt_off",  gnt_o,     2'b00);
        check_val("t1_rd_en",    rom_rd_en, 1'b1);
        check_val("t1_rom_addr", rom_addr,  8'h10);
        tick();                                     // C+2
        check_val("t1_rd_en_off",  rom_rd_en,  1'b0);
        check_val("t1_addr_hold",  rom_addr,   8'h10);
        check_val("t1_valid_early", rd_valid_o, 2'b00);
        tick();                                     // C+3
        check_val("t1_valid", rd_valid_o, 2'b01);
        check_val("t1_data",  rd_data_o,  8'h4A);
        tick();                                     // C+4
        check_val("t1_valid_off", rd_valid_o, 2'b00);
        check_val("t1_data_hold", rd_data_o,  8'h4A);
        tick();                                     // C+5
        check_val("t1_lat3_valid", rd_valid3, 2'b01);
        check_val("t1_lat3_data",  rd_data3,  8'h4A);
        tick();
        tick();

        // ---------------- requester 1 streaming 0x63..0x66 ----------------
        burst(4, 2'b10, 8'h00, 8'h63, 8'h01, 1'b0);

        // ---------------- tie, 6 cycles, addr 0x00 / 0xFF ----------------
        burst(6, 2'b11, 8'h00, 8'hFF, 8'h00, 1'b0);

        // ---------------- arb_en drops after two acceptances ----------------
        arb_en  = 1'b1;
        req_i   = 2'b11;
        addr0_i = 8'h00;
        addr1_i = 8'hFF;
        #1;
        check_val("t4_gnt_a", gnt_o, 2'b01);
        tick();                                     // A+1
        check_val("t4_gnt_b",  gnt_o,     2'b10);
        check_val("t4_rd_en1", rom_rd_en, 1'b1);
        check_val("t4_addr1",  rom_addr,  8'h00);
        tick();                                     // A+2
        arb_en = 1'b0;
        #1;
        check_val("t4_gnt_off",  gnt_o,     2'b00);
        check_val("t4_gnt3_off", gnt3,      2'b00);
        check_val("t4_rd_en2",   rom_rd_en, 1'b1);
        check_val("t4_addr2",    rom_addr,  8'hFF);
        tick();                                     // A+3
        check_val("t4_rd_en_stop", rom_rd_en,  1'b0);
        check_val("t4_valid0",     rd_valid_o, 2'b01);
        check_val("t4_data0",      rd_data_o,  8'h5A);
        tick();                                     // A+4
        check_val("t4_rd_en_stop2", rom_rd_en,  1'b0);
        check_val("t4_valid1",      rd_valid_o, 2'b10);
        check_val("t4_data1",       rd_data_o,  8'hA5);
        tick();                                     // A+5
        check_val("t4_valid_off",   rd_valid_o, 2'b00);
        check_val("t4_lat3_valid0", rd_valid3,  2'b01);
        check_val("t4_lat3_data0",  rd_data3,   8'h5A);
        tick();                                     // A+6
        check_val("t4_lat3_valid1", rd_valid3,  2'b10);
        check_val("t4_lat3_data1",  rd_data3,   8'hA5);
        check_val("t4_lat3_rd_en",  rom_rd_en3, 1'b0);
        tick();                                     // A+7
        check_val("t4_lat3_off", rd_valid3, 2'b00);

        // Request withdrawn before acceptance: no read, pointer unchanged
        arb_en = 1'b1;
        #1;
        check_val("t4_regrant", gnt_o, 2'b01);
        req_i = 2'b00;
        tick();
        check_val("t4_withdraw_rd_en", rom_rd_en, 1'b0);
        req_i = 2'b11;
        #1;
        check_val("t4_ptr_kept", gnt_o, 2'b01);
        req_i = 2'b00;
        tick();

        // ---------------- reset with a read in flight ----------------
        req_i   = 2'b01;
        addr0_i = 8'h77;
        #1;
        check_val("t5_gnt", gnt_o, 2'b01);
        tick();
        req_i = 2'b00;
        check_val("t5_rd_en", rom_rd_en, 1'b1);
        sys_rst_n = 1'b0;
        req_i     = 2'b11;
        #1;
        check_val("t5_gnt_in_rst", gnt_o,      2'b00);
        check_val("t5_rd_en_rst",  rom_rd_en,  1'b0);
        check_val("t5_addr_rst",   rom_addr,   8'h00);
        check_val("t5_valid_rst",  rd_valid_o, 2'b00);
        check_val("t5_data_rst",   rd_data_o,  8'h00);
        check_val("t5_gnt3_rst",   gnt3,       2'b00);
        tick();
        sys_rst_n = 1'b1;
        req_i     = 2'b00;
        for (int i = 0; i < 6; i++) begin
            tick();
            check_val("t5_no_pulse",      rd_valid_o, 2'b00);
            check_val("t5_no_pulse_lat3", rd_valid3,  2'b00);
        end
        req_i = 2'b11;
        #1;
        check_val("t5_tie_after_rst", gnt_o, 2'b01);
        req_i = 2'b00;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
